// File: rtl/lcd_receiver_if.sv
// DMG LCD pin bundle: frame sync, line latch, pixel clock and 2-bit pixel data.
// The video side drives the pins (master); the panel side samples them (slave).
interface lcd_receiver_if;
    logic cpg;
    logic cpl;
    logic cp;
    logic ld0;
    logic ld1;

    modport master (output cpg, output cpl, output cp, output ld0, output ld1);
    modport slave  (input  cpg, input  cpl, input  cp, input  ld0, input  ld1);
endinterface

// File: rtl/lcd_receiver.sv
// Oversampling DMG LCD pin receiver: rebuilds frames as pixel writes plus row/frame strobes.
// Define LCD_RECEIVER_SIG_EN to build the rotating-XOR frame signature; otherwise frame_sig is 0.
module lcd_receiver #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 144
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        pin_cpg,
    input  logic        pin_cpl,
    input  logic        pin_cp,
    input  logic        pin_ld0,
    input  logic        pin_ld1,
    output logic        pix_we,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [1:0]  pix_d,
    output logic        line_done,
    output logic [7:0]  line_y,
    output logic        frame_done,
    output logic        busy,
    output logic        err_short,
    output logic        err_overrun,
    output logic        err_sync,
    output logic [15:0] frame_sig
);

    localparam logic [7:0] X_END  = 8'(WIDTH);
    localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

    typedef enum logic {SYNC_WAIT, ACTIVE} state_t;

    // Pin vector order: {ld1, ld0, cp, cpl, cpg}
    logic [4:0] s1_q, s2_q, s3_q;
    logic       cp_rise, cpl_rise, cpg_lvl;
    logic [1:0] ld;

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d, y_q, y_d;
    logic       pix_we_q, pix_we_d;
    logic [7:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [1:0] pix_d_q, pix_d_d;
    logic       line_done_q, line_done_d;
    logic [7:0] line_y_q, line_y_d;
    logic       frame_done_q, frame_done_d;
    logic       err_short_q, err_short_d;
    logic       err_overrun_q, err_overrun_d;
    logic       err_sync_q, err_sync_d;
`ifdef LCD_RECEIVER_SIG_EN
    logic [15:0] sig_q, sig_d, frame_sig_q, frame_sig_d;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= {pin_ld1, pin_ld0, pin_cp, pin_cpl, pin_cpg};
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign cp_rise  = s2_q[2] & ~s3_q[2];
    assign cpl_rise = s2_q[1] & ~s3_q[1];
    assign cpg_lvl  = s2_q[0];
    assign ld       = s2_q[4:3];

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        pix_we_d      = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_d_d       = pix_d_q;
        line_done_d   = 1'b0;
        line_y_d      = line_y_q;
        frame_done_d  = 1'b0;
        err_short_d   = 1'b0;
        err_overrun_d = 1'b0;
        err_sync_d    = 1'b0;
`ifdef LCD_RECEIVER_SIG_EN
        sig_d         = sig_q;
        frame_sig_d   = frame_sig_q;
`endif
        case (state_q)
            SYNC_WAIT: begin
                if (cpl_rise && cpg_lvl) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
`ifdef LCD_RECEIVER_SIG_EN
                    sig_d   = '0;
`endif
                end
            end
            ACTIVE: begin
                // Pixel goes first so a coincident CPL commits a row that includes it.
                if (cp_rise) begin
                    if (x_q < X_END) begin
                        pix_we_d = 1'b1;
                        pix_x_d  = x_q;
                        pix_y_d  = y_q;
                        pix_d_d  = ld;
                        x_d      = x_q + 8'd1;
`ifdef LCD_RECEIVER_SIG_EN
                        sig_d    = {sig_q[14:0], sig_q[15]} ^ {14'b0, ld};
`endif
                    end else begin
                        err_overrun_d = 1'b1;
                    end
                end
                if (cpl_rise) begin
                    if (cpg_lvl) begin
                        err_sync_d = 1'b1;
                        x_d        = '0;
                        y_d        = '0;
`ifdef LCD_RECEIVER_SIG_EN
                        sig_d      = '0;
`endif
                    end else begin
                        line_done_d = 1'b1;
                        line_y_d    = y_q;
                        err_short_d = (x_d != X_END);
                        x_d         = '0;
                        if (y_q == Y_LAST) begin
                            frame_done_d = 1'b1;
                            y_d          = '0;
                            state_d      = SYNC_WAIT;
`ifdef LCD_RECEIVER_SIG_EN
                            frame_sig_d  = sig_d;
`endif
                        end else begin
                            y_d = y_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = SYNC_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= SYNC_WAIT;
            x_q           <= '0;
            y_q           <= '0;
            pix_we_q      <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_d_q       <= '0;
            line_done_q   <= 1'b0;
            line_y_q      <= '0;
            frame_done_q  <= 1'b0;
            err_short_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            err_sync_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_we_q      <= pix_we_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_d_q       <= pix_d_d;
            line_done_q   <= line_done_d;
            line_y_q      <= line_y_d;
            frame_done_q  <= frame_done_d;
            err_short_q   <= err_short_d;
            err_overrun_q <= err_overrun_d;
            err_sync_q    <= err_sync_d;
        end
    end

`ifdef LCD_RECEIVER_SIG_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sig_q       <= '0;
            frame_sig_q <= '0;
        end else begin
            sig_q       <= sig_d;
            frame_sig_q <= frame_sig_d;
        end
    end
    assign frame_sig = frame_sig_q;
`else
    assign frame_sig = '0;
`endif

    assign pix_we      = pix_we_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_d       = pix_d_q;
    assign line_done   = line_done_q;
    assign line_y      = line_y_q;
    assign frame_done  = frame_done_q;
    assign busy        = (state_q == ACTIVE);
    assign err_short   = err_short_q;
    assign err_overrun = err_overrun_q;
    assign err_sync    = err_sync_q;

endmodule

// File: tb/tb_lcd_receiver.sv
// Directed bench for lcd_receiver on a reduced 16x8 panel so whole frames stay short.
module tb_lcd_receiver;
    localparam int W = 16;
    localparam int H = 8;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    lcd_receiver_if pins ();

    logic        pix_we, line_done, frame_done, busy, err_short, err_overrun, err_sync;
    logic [7:0]  pix_x, pix_y, line_y;
    logic [1:0]  pix_d;
    logic [15:0] frame_sig;

    lcd_receiver #(.WIDTH(W), .HEIGHT(H)) u_dut (
        .clk(clk), .nreset(nreset),
        .pin_cpg(pins.cpg), .pin_cpl(pins.cpl), .pin_cp(pins.cp),
        .pin_ld0(pins.ld0), .pin_ld1(pins.ld1),
        .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_d(pix_d),
        .line_done(line_done), .line_y(line_y), .frame_done(frame_done), .busy(busy),
        .err_short(err_short), .err_overrun(err_overrun), .err_sync(err_sync),
        .frame_sig(frame_sig)
    );

    int nt = 0;
    int nf = 0;

    // Strobe monitor: counts events and remembers the most recent payloads.
    int n_we = 0, n_line = 0, n_frame = 0, n_short = 0, n_over = 0, n_sync = 0, n_short_line = 0;
    logic [7:0] last_x = '0, last_y = '0, last_ly = '0;
    logic [1:0] last_d = '0;
    logic [7:0] line_log [0:255];

    always @(negedge clk) begin
        if (pix_we) begin
            n_we++; last_x = pix_x; last_y = pix_y; last_d = pix_d;
        end
        if (line_done) begin
            line_log[n_line % 256] = line_y; n_line++; last_ly = line_y;
        end
        if (frame_done) n_frame++;
        if (err_short) n_short++;
        if (err_overrun) n_over++;
        if (err_sync) n_sync++;
        if (err_short && line_done) n_short_line++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cp_pix(input logic [1:0] v);
        pins.ld0 = v[0]; pins.ld1 = v[1]; pins.cp = 1'b1;
        tick(2);
        pins.cp = 1'b0;
        tick(2);
    endtask

    task automatic cpl_pulse(input logic g);
        pins.cpg = g; pins.cpl = 1'b1;
        tick(2);
        pins.cpl = 1'b0; pins.cpg = 1'b0;
        tick(2);
    endtask

    task automatic reset_dut();
        pins.cpg = 1'b0; pins.cpl = 1'b0; pins.cp = 1'b0; pins.ld0 = 1'b0; pins.ld1 = 1'b0;
        nreset = 1'b0;
        tick(1);
        nreset = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        tick(2);
        nt++; if ({pix_we, line_done, frame_done, busy, err_short, err_overrun, err_sync} !== 7'b0) begin
            nf++; $display("FAIL reset_strobes got %b want 0", {pix_we, line_done, frame_done, busy, err_short, err_overrun, err_sync}); end
        nt++; if ({pix_x, pix_y, pix_d} !== 18'b0) begin
            nf++; $display("FAIL reset_pix got %h want 0", {pix_x, pix_y, pix_d}); end
        nt++; if (line_y !== 8'd0) begin nf++; $display("FAIL reset_line_y got %0d want 0", line_y); end
        nt++; if (frame_sig !== 16'd0) begin nf++; $display("FAIL reset_frame_sig got %h want 0", frame_sig); end
        nreset = 1'b1;
        tick(2);
    endtask

    task automatic test_latency();
        reset_dut();
        pins.cpg = 1'b1; pins.cpl = 1'b1;
        tick(2);
        nt++; if (busy !== 1'b0) begin nf++; $display("FAIL busy_early got %b want 0", busy); end
        tick(1);
        nt++; if (busy !== 1'b1) begin nf++; $display("FAIL busy_latency3 got %b want 1", busy); end
        pins.cpl = 1'b0; pins.cpg = 1'b0;
        tick(2);
    endtask

    task automatic test_full_frame();
        int b_we, b_line, b_frame, b_err, bad;
        logic [15:0] msig, want_sig;
        logic [1:0] v;
        reset_dut();
        b_we = n_we; b_line = n_line; b_frame = n_frame; b_err = n_short + n_over + n_sync;
        msig = '0;
        cpl_pulse(1'b1);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                v = 2'((x + 3 * y) % 4);
                msig = {msig[14:0], msig[15]} ^ {14'b0, v};
                cp_pix(v);
            end
            cpl_pulse(1'b0);
        end
        tick(2);
        nt++; if (n_we - b_we !== W * H) begin nf++; $display("FAIL frame_writes got %0d want %0d", n_we - b_we, W * H); end
        nt++; if (n_line - b_line !== H) begin nf++; $display("FAIL frame_lines got %0d want %0d", n_line - b_line, H); end
        nt++; if (n_frame - b_frame !== 1) begin nf++; $display("FAIL frame_done_cnt got %0d want 1", n_frame - b_frame); end
        nt++; if (n_short + n_over + n_sync - b_err !== 0) begin
            nf++; $display("FAIL frame_errors got %0d want 0", n_short + n_over + n_sync - b_err); end
        bad = 0;
        for (int i = 0; i < H; i++) if (line_log[(b_line + i) % 256] !== 8'(i)) bad++;
        nt++; if (bad !== 0) begin nf++; $display("FAIL frame_line_y_seq got %0d bad entries want 0", bad); end
        nt++; if ({last_x, last_y, last_d} !== {8'(W - 1), 8'(H - 1), 2'((W - 1 + 3 * (H - 1)) % 4)}) begin
            nf++; $display("FAIL frame_last_pix got %0d,%0d,%0d", last_x, last_y, last_d); end
        nt++; if (busy !== 1'b0) begin nf++; $display("FAIL frame_busy_end got %b want 0", busy); end
`ifdef LCD_RECEIVER_SIG_EN
        want_sig = msig;
`else
        want_sig = 16'd0;
`endif
        nt++; if (frame_sig !== want_sig) begin nf++; $display("FAIL frame_sig got %h want %h", frame_sig, want_sig); end
    endtask

    task automatic test_short_row();
        int b_short, b_sl, b_line;
        reset_dut();
        b_short = n_short; b_sl = n_short_line; b_line = n_line;
        cpl_pulse(1'b1);
        for (int x = 0; x < W - 1; x++) cp_pix(2'd1);
        cpl_pulse(1'b0);
        nt++; if (n_short - b_short !== 1) begin nf++; $display("FAIL short_cnt got %0d want 1", n_short - b_short); end
        nt++; if (n_short_line - b_sl !== 1) begin nf++; $display("FAIL short_with_line got %0d want 1", n_short_line - b_sl); end
        nt++; if (n_line - b_line !== 1 || last_ly !== 8'd0) begin
            nf++; $display("FAIL short_line_y got %0d lines y=%0d want 1 y=0", n_line - b_line, last_ly); end
        cp_pix(2'd2);
        nt++; if ({last_x, last_y, last_d} !== {8'd0, 8'd1, 2'd2}) begin
            nf++; $display("FAIL short_next_pix got %0d,%0d,%0d want 0,1,2", last_x, last_y, last_d); end
    endtask

    task automatic test_overrun();
        int b_we, b_over, b_short, b_line;
        reset_dut();
        b_we = n_we; b_over = n_over; b_short = n_short; b_line = n_line;
        cpl_pulse(1'b1);
        for (int x = 0; x < W + 1; x++) cp_pix(2'd1);
        nt++; if (n_we - b_we !== W) begin nf++; $display("FAIL overrun_writes got %0d want %0d", n_we - b_we, W); end
        nt++; if (n_over - b_over !== 1) begin nf++; $display("FAIL overrun_cnt got %0d want 1", n_over - b_over); end
        nt++; if (last_x !== 8'(W - 1)) begin nf++; $display("FAIL overrun_last_x got %0d want %0d", last_x, W - 1); end
        cpl_pulse(1'b0);
        nt++; if (n_short - b_short !== 0 || n_line - b_line !== 1) begin
            nf++; $display("FAIL overrun_commit got short=%0d lines=%0d want 0,1", n_short - b_short, n_line - b_line); end
    endtask

    task automatic test_sync_error();
        int b_sync, b_line;
        reset_dut();
        b_sync = n_sync; b_line = n_line;
        cpl_pulse(1'b1);
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < W; x++) cp_pix(2'd0);
            cpl_pulse(1'b0);
        end
        for (int x = 0; x < 5; x++) cp_pix(2'd1);
        cpl_pulse(1'b1);
        nt++; if (n_sync - b_sync !== 1) begin nf++; $display("FAIL sync_cnt got %0d want 1", n_sync - b_sync); end
        nt++; if (n_line - b_line !== 3) begin nf++; $display("FAIL sync_no_line got %0d want 3", n_line - b_line); end
        nt++; if (busy !== 1'b1) begin nf++; $display("FAIL sync_busy got %b want 1", busy); end
        cp_pix(2'd3);
        nt++; if ({last_x, last_y, last_d} !== {8'd0, 8'd0, 2'd3}) begin
            nf++; $display("FAIL sync_restart_pix got %0d,%0d,%0d want 0,0,3", last_x, last_y, last_d); end
    endtask

    task automatic test_same_cycle();
        int b_we, b_short, b_line;
        reset_dut();
        cpl_pulse(1'b1);
        for (int x = 0; x < W - 1; x++) cp_pix(2'd0);
        b_we = n_we; b_short = n_short; b_line = n_line;
        pins.ld0 = 1'b0; pins.ld1 = 1'b1; pins.cpg = 1'b0; pins.cp = 1'b1; pins.cpl = 1'b1;
        tick(2);
        pins.cp = 1'b0; pins.cpl = 1'b0;
        tick(2);
        nt++; if (n_we - b_we !== 1 || {last_x, last_y, last_d} !== {8'(W - 1), 8'd0, 2'd2}) begin
            nf++; $display("FAIL same_cycle_pix got n=%0d at %0d,%0d,%0d", n_we - b_we, last_x, last_y, last_d); end
        nt++; if (n_line - b_line !== 1 || n_short - b_short !== 0) begin
            nf++; $display("FAIL same_cycle_commit got lines=%0d short=%0d want 1,0", n_line - b_line, n_short - b_short); end
    endtask

    task automatic test_reset_mid();
        int b_we, b_line;
        reset_dut();
        cpl_pulse(1'b1);
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < W; x++) cp_pix(2'd2);
            cpl_pulse(1'b0);
        end
        for (int x = 0; x < 5; x++) cp_pix(2'd3);
        pins.cp = 1'b1;
        tick(1);
        nreset = 1'b0;
        #1;
        nt++; if ({pix_we, line_done, frame_done, busy, err_short, err_overrun, err_sync, pix_x, pix_y, pix_d, line_y, frame_sig} !== '0) begin
            nf++; $display("FAIL reset_mid_outputs got busy=%b x=%0d y=%0d ly=%0d want all 0", busy, pix_x, pix_y, line_y); end
        tick(1);
        nreset = 1'b1;
        pins.cp = 1'b0;
        tick(2);
        b_we = n_we; b_line = n_line;
        for (int x = 0; x < 3; x++) cp_pix(2'd1);
        cpl_pulse(1'b0);
        nt++; if (n_we - b_we !== 0 || n_line - b_line !== 0) begin
            nf++; $display("FAIL reset_mid_ignored got we=%0d lines=%0d want 0,0", n_we - b_we, n_line - b_line); end
        cpl_pulse(1'b1);
        cp_pix(2'd1);
        nt++; if (n_we - b_we !== 1 || {last_x, last_y} !== 16'd0) begin
            nf++; $display("FAIL reset_mid_restart got we=%0d at %0d,%0d want 1 at 0,0", n_we - b_we, last_x, last_y); end
    endtask

    task automatic test_sig();
        logic [15:0] msig, want, first;
        int b_frame;
        reset_dut();
        b_frame = n_frame;
        msig = '0;
        for (int i = 0; i < W * H; i++) msig = {msig[14:0], msig[15]} ^ 16'd3;
`ifdef LCD_RECEIVER_SIG_EN
        want = msig;
`else
        want = 16'd0;
`endif
        for (int f = 0; f < 2; f++) begin
            cpl_pulse(1'b1);
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) cp_pix(2'd3);
                cpl_pulse(1'b0);
            end
            if (f == 0) begin
                first = frame_sig;
                nt++; if (first !== want) begin nf++; $display("FAIL sig_frame1 got %h want %h", first, want); end
                cp_pix(2'd1);
                nt++; if (frame_sig !== want) begin nf++; $display("FAIL sig_hold got %h want %h", frame_sig, want); end
            end
        end
        nt++; if (frame_sig !== want || n_frame - b_frame !== 2) begin
            nf++; $display("FAIL sig_frame2 got %h frames=%0d want %h frames=2", frame_sig, n_frame - b_frame, want); end
    endtask

    initial begin
        pins.cpg = 1'b0; pins.cpl = 1'b0; pins.cp = 1'b0; pins.ld0 = 1'b0; pins.ld1 = 1'b0;
        test_reset();
        test_latency();
        test_full_frame();
        test_short_row();
        test_overrun();
        test_sync_error();
        test_same_cycle();
        test_reset_mid();
        test_sig();
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end
endmodule

// File: doc/lcd_receiver.md
# lcd_receiver

Behavioural receiver for the DMG LCD pin interface: the panel-side consumer of the frame sync, line latch, pixel clock and 2-bit pixel data driven out by the video control logic. It oversamples the pins on one fast system clock and reconstructs each frame as a stream of pixel writes with row/frame completion strobes. Protocol errors are flagged, so video benches can check the video pipeline end to end against a frame image.

## Interface
Parameters:
- `WIDTH`, 160, pixels per row
- `HEIGHT`, 144, visible rows per frame

Ports:
- `clk`  in  1  sampling clock; at least 4x the pin_cp rate
- `nreset`  in  1  asynchronous reset, active-low
- `pin_cpg`  in  1  frame sync (CPG) from the video block
- `pin_cpl`  in  1  line latch (CPL)
- `pin_cp`  in  1  pixel clock (CP)
- `pin_ld0`, `pin_ld1`  in  1 each  pixel data bits 0 and 1
- `pix_we`  out  1  one-cycle pixel write strobe
- `pix_x`, `pix_y`  out  8 each  pixel coordinate, valid with pix_we
- `pix_d`  out  2  pixel value {ld1,ld0}, valid with pix_we
- `line_done`  out  1  one-cycle strobe: a row was committed
- `line_y`  out  8  index of the committed row, held until the next commit
- `frame_done`  out  1  one-cycle strobe: row HEIGHT-1 was committed
- `busy`  out  1  high in ACTIVE
- `err_short`  out  1  strobe: a row was committed with x != WIDTH
- `err_overrun`  out  1  strobe: a CP edge arrived with x == WIDTH
- `err_sync`  out  1  strobe: CPG seen at a CPL edge in mid-frame
- `frame_sig`  out  16  frame signature (see Configuration)

## Operation
- Every pin passes through a 2-flop synchroniser and then a third edge-detect stage. A "rise" means the stage-2 value is 1 and the stage-3 value is 0.
- Pixel data is taken from stage 2 in the same cycle as the CP rise.
- Two states: SYNC_WAIT (reset state) and ACTIVE.
- SYNC_WAIT:
  - CP rises are ignored and produce no error.
  - A CPL rise with CPG=1 moves to ACTIVE and sets x=0, y=0, signature=0.
  - A CPL rise with CPG=0 is ignored. This covers the vblank lines.
- ACTIVE, CP rise:
  - If x < WIDTH: pulse pix_we with pix_x=x, pix_y=y, pix_d={ld1,ld0}, then x++.
  - Otherwise: pulse err_overrun, no write, x holds.
- ACTIVE, CPL rise with CPG=0 (commit):
  - Pulse line_done with line_y=y.
  - Also pulse err_short if x != WIDTH.
  - Set x=0.
  - If y == HEIGHT-1: pulse frame_done, set y=0, go to SYNC_WAIT. Otherwise y++.
- ACTIVE, CPL rise with CPG=1:
  - Pulse err_sync. No line_done.
  - Restart the frame: x=0, y=0, signature=0, stay in ACTIVE.
- CP rise and CPL rise in the same cycle: the pixel is processed first (written at the current x, y and counted in x), then the CPL action applies.
- x is 8 bits and never exceeds WIDTH. y never exceeds HEIGHT-1.
- Reset mid-frame: all state clears immediately, back to SYNC_WAIT. The partial frame is discarded with no strobes.

## Timing
- Reset values: every output 0, including frame_sig, line_y, pix_x, pix_y and pix_d.
- Latency from a pin edge to its strobe is 3 clk cycles (two synchroniser flops plus the edge-detect register).
- Strobes are exactly one clk wide. pix_x, pix_y and pix_d are registered and change only together with pix_we.
- Minimum spacing between same-pin edges is 2 clk. Closer spacing is outside the protocol; its behaviour is not checked.
- busy rises 3 cycles after the frame-start CPL rise. It falls in the same cycle as frame_done.

## Configuration
- `LCD_RECEIVER_SIG_EN` defined:
  - On every pix_we: sig = {sig[14:0], sig[15]} ^ {14'b0, pix_d}.
  - sig clears at frame start and on err_sync.
  - frame_sig loads the final sig in the cycle frame_done pulses and holds until the next frame_done.
- `LCD_RECEIVER_SIG_EN` undefined: no signature logic; frame_sig is tied to 0.

## Test plan
- Reset, then a CPL rise with CPG=1, then 144 rows of 160 CP pulses, each row followed by a CPL rise -> 23040 pix_we strobes, 144 line_done strobes with line_y 0..143, one frame_done, no error strobes.
- Row with 159 CP pulses, then CPL -> err_short and line_done in the same cycle, line_y=current row; the next row starts at pix_x=0.
- Row with 161 CP pulses -> 160 writes, err_overrun exactly once; the 161st edge produces no pix_we.
- CPL rise with CPG=1 at row 50 -> err_sync, no line_done; the next pixel is written at (0,0).
- nreset pulsed low mid-row 10 -> all outputs 0 in the same cycle; CP pulses are then ignored until a CPL rise with CPG=1.
- With LCD_RECEIVER_SIG_EN defined: a frame of all pixel value 3 -> frame_sig equals the bench model's value, and is unchanged after a second identical frame.
